// File: rtl/system_timer_mc_if.sv
// Bus slave port of the machine timer: decoded word addresses, write data,
// read/write selects and registered read data.
interface system_timer_mc_if;
  logic [7:2]  raddr;
  logic [7:2]  waddr;
  logic [31:0] wdata;
  logic        ren;
  logic        wen;
  logic [31:0] rdata;

  modport master (output raddr, waddr, wdata, ren, wen, input rdata);
  modport slave  (input raddr, waddr, wdata, ren, wen, output rdata);
endinterface

// File: rtl/system_timer_mc.sv
// Machine timer: 64-bit mtime advanced by a prescaler or a synchronised external tick,
// NUM_CMP one-shot/periodic compare channels with level IRQs, shadowed mtime high word.
module system_timer_mc #(
  parameter int unsigned NUM_CMP    = 4,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic               hb_clk,
  input  logic               hb_rst_n,
  system_timer_mc_if.slave   xt_hb,
  input  logic               tick_ext,
  output logic [NUM_CMP-1:0] irq,
  output logic               mtimer_int
);

  localparam logic [5:0] AddrCtrl   = 6'h00;
  localparam logic [5:0] AddrStatus = 6'h01;
  localparam logic [5:0] AddrMtimeL = 6'h02;
  localparam logic [5:0] AddrMtimeH = 6'h03;

  logic                  run_q, src_q;
  logic [PRESCALE_W-1:0] div_q, presc_q, presc_d;
  logic [2:0]            sync_q;
  logic [63:0]           mtime_q, mtime_d;
  logic [31:0]           shadow_h_q;
  logic [63:0]           cmp_q [NUM_CMP];
  logic [63:0]           cmp_d [NUM_CMP];
  logic [31:0]           period_q [NUM_CMP];
  logic [NUM_CMP-1:0]    en_q, periodic_q, pending_q, pending_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mtint_q;

  logic               wr_ctrl, wr_status, wr_mtime_l, wr_mtime_h, rd_mtime_l;
  logic [NUM_CMP-1:0] wr_cmp_l, wr_cmp_h, wr_period, wr_ch_ctrl, ch_clr, hit, set;
  logic               tick;

  assign wr_ctrl    = xt_hb.wen && (xt_hb.waddr == AddrCtrl);
  assign wr_status  = xt_hb.wen && (xt_hb.waddr == AddrStatus);
  assign wr_mtime_l = xt_hb.wen && (xt_hb.waddr == AddrMtimeL);
  assign wr_mtime_h = xt_hb.wen && (xt_hb.waddr == AddrMtimeH);
  assign rd_mtime_l = xt_hb.ren && (xt_hb.raddr == AddrMtimeL);

  // Channel n occupies word addresses {n+1, 2'bxx}.
  always_comb begin
    for (int n = 0; n < NUM_CMP; n++) begin
      wr_cmp_l[n]   = xt_hb.wen && (xt_hb.waddr == {4'(n + 1), 2'd0});
      wr_cmp_h[n]   = xt_hb.wen && (xt_hb.waddr == {4'(n + 1), 2'd1});
      wr_period[n]  = xt_hb.wen && (xt_hb.waddr == {4'(n + 1), 2'd2});
      wr_ch_ctrl[n] = xt_hb.wen && (xt_hb.waddr == {4'(n + 1), 2'd3});
    end
  end

  assign ch_clr = wr_cmp_l | wr_cmp_h | wr_ch_ctrl;

  // sync_q[1:0] is the synchroniser, sync_q[2] the previous value for edge detection.
  always_comb begin
    tick = 1'b0;
    if (run_q) begin
      tick = src_q ? (sync_q[1] && !sync_q[2]) : (presc_q == div_q);
    end
  end

  always_comb begin
    presc_d = presc_q + PRESCALE_W'(1);
    if (wr_ctrl || !run_q || src_q || tick) begin
      presc_d = '0;
    end
  end

  // A bus write to either mtime half swallows a same-cycle tick.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mtime_l) begin
      mtime_d[31:0] = xt_hb.wdata;
    end else if (wr_mtime_h) begin
      mtime_d[63:32] = xt_hb.wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_CMP; n++) begin
      hit[n] = en_q[n] && (mtime_q >= cmp_q[n]);
    end
    // A set is only the 0->1 event, so W1C of a held hit drops pending for one cycle.
    set       = hit & ~pending_q;
    pending_d = pending_q;
    if (wr_status) begin
      pending_d = pending_d & ~xt_hb.wdata[NUM_CMP-1:0];
    end
    pending_d = (pending_d | set) & ~ch_clr;
    for (int n = 0; n < NUM_CMP; n++) begin
      cmp_d[n] = cmp_q[n];
      if (wr_cmp_l[n]) begin
        cmp_d[n][31:0] = xt_hb.wdata;
      end else if (wr_cmp_h[n]) begin
        cmp_d[n][63:32] = xt_hb.wdata;
      end else if (set[n] && !ch_clr[n] && periodic_q[n] && (period_q[n] != '0)) begin
        cmp_d[n] = cmp_q[n] + {32'd0, period_q[n]};
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (xt_hb.ren) begin
      rdata_d = '0;
      case (xt_hb.raddr)
        AddrCtrl: begin
          rdata_d[0]               = run_q;
          rdata_d[1]               = src_q;
          rdata_d[16+:PRESCALE_W]  = div_q;
        end
        AddrStatus: rdata_d[NUM_CMP-1:0] = pending_q;
        AddrMtimeL: rdata_d = mtime_q[31:0];
        AddrMtimeH: rdata_d = shadow_h_q;
        default: begin
          for (int n = 0; n < NUM_CMP; n++) begin
            if (xt_hb.raddr[7:4] == 4'(n + 1)) begin
              case (xt_hb.raddr[3:2])
                2'd0:    rdata_d = cmp_q[n][31:0];
                2'd1:    rdata_d = cmp_q[n][63:32];
                2'd2:    rdata_d = period_q[n];
                default: rdata_d = {30'd0, periodic_q[n], en_q[n]};
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      run_q      <= 1'b1;
      src_q      <= 1'b0;
      div_q      <= '0;
      presc_q    <= '0;
      sync_q     <= '0;
      mtime_q    <= '0;
      shadow_h_q <= '0;
      en_q       <= '0;
      periodic_q <= '0;
      pending_q  <= '0;
      mtint_q    <= 1'b0;
      rdata_q    <= '0;
      for (int n = 0; n < NUM_CMP; n++) begin
        cmp_q[n]    <= '0;
        period_q[n] <= '0;
      end
    end else begin
      if (wr_ctrl) begin
        run_q <= xt_hb.wdata[0];
        src_q <= xt_hb.wdata[1];
        div_q <= xt_hb.wdata[16+:PRESCALE_W];
      end
      presc_q <= presc_d;
      sync_q  <= {sync_q[1:0], tick_ext};
      mtime_q <= mtime_d;
      if (rd_mtime_l) begin
        shadow_h_q <= mtime_q[63:32];
      end
      for (int n = 0; n < NUM_CMP; n++) begin
        cmp_q[n] <= cmp_d[n];
        if (wr_period[n]) begin
          period_q[n] <= xt_hb.wdata;
        end
        if (wr_ch_ctrl[n]) begin
          en_q[n]       <= xt_hb.wdata[0];
          periodic_q[n] <= xt_hb.wdata[1];
        end
      end
      pending_q <= pending_d;
      mtint_q   <= |pending_d;
      rdata_q   <= rdata_d;
    end
  end

  assign irq         = pending_q;
  assign mtimer_int  = mtint_q;
  assign xt_hb.rdata = rdata_q;

endmodule
